// File: rtl/debug_pkg.sv
// Shared constants for the register dump path: FSM encoding, word/byte geometry
// and the byte order used on the UART stream.
package debug_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_SEND = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int NB_REG_DEF  = 5;
  localparam int NB_DATA_DEF = 32;
  localparam int NB_BYTE_DEF = 8;

  localparam int BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE_DEF;

  // Bytes leave the serializer most-significant first.
  localparam bit MSB_FIRST = 1'b1;

  function automatic int bytes_per_word(input int nb_data, input int nb_byte);
    return nb_data / nb_byte;
  endfunction

endpackage

// File: rtl/register_dump_unit_if.sv
// Bundle of the dump unit's control, bank read port and byte-stream signals.
// slave is the dump unit's view; master is the surrounding system's view.
interface register_dump_unit_if
  import debug_pkg::*;
#(
  parameter int NB_REG  = NB_REG_DEF,
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_BYTE = NB_BYTE_DEF
);

  logic               start_i;
  logic [NB_REG-1:0]  dump_addr_o;
  logic [NB_DATA-1:0] dump_data_i;
  logic [NB_BYTE-1:0] tx_data_o;
  logic               tx_valid_o;
  logic               tx_ready_i;
  logic               busy_o;
  logic               done_o;

  modport slave (
    input  start_i,
    input  dump_data_i,
    input  tx_ready_i,
    output dump_addr_o,
    output tx_data_o,
    output tx_valid_o,
    output busy_o,
    output done_o
  );

  modport master (
    output start_i,
    output dump_data_i,
    output tx_ready_i,
    input  dump_addr_o,
    input  tx_data_o,
    input  tx_valid_o,
    input  busy_o,
    input  done_o
  );

endinterface

// File: rtl/word_serializer.sv
// Splits one loaded word into bytes on a valid/ready stream; last_o marks the
// transfer of the final byte of the word.
module word_serializer
  import debug_pkg::*;
#(
  parameter int NB_DATA    = NB_DATA_DEF,
  parameter int NB_BYTE    = NB_BYTE_DEF,
  parameter bit BYTE_ORDER = MSB_FIRST
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [NB_DATA-1:0] word_i,
  input  logic               ready_i,
  output logic [NB_BYTE-1:0] data_o,
  output logic               valid_o,
  output logic               last_o
);

  localparam int BPW    = bytes_per_word(NB_DATA, NB_BYTE);
  localparam int NB_CNT = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(BPW - 1);

  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_CNT-1:0]  byte_cnt_q, byte_cnt_d;
  logic               valid_q, valid_d;
  logic               xfer;

  assign xfer    = valid_q & ready_i;
  assign last_o  = xfer & (byte_cnt_q == CNT_LAST);
  assign valid_o = valid_q;
  assign data_o  = BYTE_ORDER ? shift_q[NB_DATA-1 -: NB_BYTE] : shift_q[NB_BYTE-1:0];

  // Data and valid only move on a transfer, so a stalled byte stays put.
  always_comb begin
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    valid_d    = valid_q;
    if (load_i) begin
      shift_d    = word_i;
      byte_cnt_d = '0;
      valid_d    = 1'b1;
    end else if (xfer) begin
      shift_d    = BYTE_ORDER ? (shift_q << NB_BYTE) : (shift_q >> NB_BYTE);
      byte_cnt_d = byte_cnt_q + NB_CNT'(1);
      if (byte_cnt_q == CNT_LAST) begin
        byte_cnt_d = '0;
        valid_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: rtl/register_dump_unit.sv
// Walks the register bank through its read port and streams every word out
// as bytes to the UART transmitter.
//
// state | meaning
// IDLE  | waiting for start_i
// READ  | present reg_cnt on dump_addr_o, arm latency counter
// WAIT  | hold address until bank data is valid, then load serializer
// SEND  | serializer emits the word's bytes
// DONE  | one-cycle completion pulse, back to IDLE
module register_dump_unit
  import debug_pkg::*;
#(
  parameter int NB_REG     = NB_REG_DEF,
  parameter int NB_DATA    = NB_DATA_DEF,
  parameter int N_REGISTER = 32,
  parameter int RD_LATENCY = 1,
  parameter int NB_BYTE    = NB_BYTE_DEF
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  register_dump_unit_if.slave  bus
);

  localparam int NB_LAT = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [NB_REG-1:0] REG_LAST = NB_REG'(N_REGISTER - 1);
  localparam logic [NB_LAT-1:0] LAT_INIT = NB_LAT'(RD_LATENCY - 1);

  logic [2:0]        state_q, state_d;
  logic [NB_REG-1:0] reg_cnt_q, reg_cnt_d;
  logic [NB_LAT-1:0] lat_cnt_q, lat_cnt_d;
  logic              ser_load;
  logic              ser_last;

  always_comb begin
    state_d   = state_q;
    reg_cnt_d = reg_cnt_q;
    lat_cnt_d = lat_cnt_q;
    ser_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          reg_cnt_d = '0;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        lat_cnt_d = LAT_INIT;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_cnt_q == '0) begin
          ser_load = 1'b1;
          state_d  = ST_SEND;
        end else begin
          lat_cnt_d = lat_cnt_q - NB_LAT'(1);
        end
      end
      ST_SEND: begin
        if (ser_last) begin
          if (reg_cnt_q == REG_LAST) begin
            state_d = ST_DONE;
          end else begin
            reg_cnt_d = reg_cnt_q + NB_REG'(1);
            state_d   = ST_READ;
          end
        end
      end
      ST_DONE: begin
        reg_cnt_d = '0;
        state_d   = ST_IDLE;
      end
      default: begin
        reg_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      reg_cnt_q <= '0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      reg_cnt_q <= reg_cnt_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // Address stays on reg_cnt through WAIT so the registered bank output is stable.
  assign bus.dump_addr_o = reg_cnt_q;
  assign bus.busy_o      = (state_q == ST_READ) || (state_q == ST_WAIT) || (state_q == ST_SEND);
  assign bus.done_o      = (state_q == ST_DONE);

  word_serializer #(
    .NB_DATA    (NB_DATA),
    .NB_BYTE    (NB_BYTE),
    .BYTE_ORDER (MSB_FIRST)
  ) u_word_serializer (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .load_i  (ser_load),
    .word_i  (bus.dump_data_i),
    .ready_i (bus.tx_ready_i),
    .data_o  (bus.tx_data_o),
    .valid_o (bus.tx_valid_o),
    .last_o  (ser_last)
  );

endmodule

// File: tb/tb_register_dump_unit.sv
// Directed bench for register_dump_unit: default-latency instance plus a
// RD_LATENCY=2 instance, each fed by a registered bank model.
module tb_register_dump_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] bank [32];

  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic ready0 = 1'b1;
  logic ready1 = 1'b1;
  int   rmode  = 0;

  register_dump_unit_if if0 ();
  register_dump_unit_if if1 ();

  logic [31:0] rd0_q, rd1a_q, rd1b_q;

  assign if0.start_i     = start0;
  assign if0.tx_ready_i  = ready0;
  assign if0.dump_data_i = rd0_q;
  assign if1.start_i     = start1;
  assign if1.tx_ready_i  = ready1;
  assign if1.dump_data_i = rd1b_q;

  register_dump_unit u_dut0 (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (if0.slave)
  );

  register_dump_unit #(.RD_LATENCY(2)) u_dut1 (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (if1.slave)
  );

  always @(posedge clk) begin
    rd0_q  <= bank[if0.dump_addr_o];
    rd1a_q <= bank[if1.dump_addr_o];
    rd1b_q <= rd1a_q;
  end

  // Ready pattern for DUT0: 0 = always, 1 = one cycle in three, 2 = never.
  always @(posedge clk) begin
    #1;
    case (rmode)
      1:       ready0 = (cyc % 3 == 0);
      2:       ready0 = 1'b0;
      default: ready0 = 1'b1;
    endcase
  end

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int start_cyc0 = 0, start_cyc1 = 0;
  int done_cnt0 = 0, done_cyc0 = 0, busy_cnt0 = 0, busy_first0 = 0, busy_last0 = 0;
  int stall_seen0 = 0, stall_viol0 = 0;
  int done_cnt1 = 0, done_cyc1 = 0;
  logic       p_valid = 1'b0, p_ready = 1'b0;
  logic [7:0] p_data  = '0;

  always @(negedge clk) begin
    if (rst) begin
      p_valid = 1'b0;
    end else begin
      if (if0.tx_valid_o && if0.tx_ready_i) q0.push_back(if0.tx_data_o);
      if (if0.done_o) begin
        done_cnt0++;
        done_cyc0 = cyc - start_cyc0 + 1;
      end
      if (if0.busy_o) begin
        busy_cnt0++;
        if (busy_first0 == 0) busy_first0 = cyc - start_cyc0 + 1;
        busy_last0 = cyc - start_cyc0 + 1;
      end
      if (p_valid && !p_ready) begin
        stall_seen0++;
        if (!(if0.tx_valid_o === 1'b1 && if0.tx_data_o === p_data)) stall_viol0++;
      end
      p_valid = if0.tx_valid_o;
      p_ready = if0.tx_ready_i;
      p_data  = if0.tx_data_o;
      if (if1.tx_valid_o && if1.tx_ready_i) q1.push_back(if1.tx_data_o);
      if (if1.done_o) begin
        done_cnt1++;
        done_cyc1 = cyc - start_cyc1 + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    q0.delete();
    q1.delete();
    done_cnt0 = 0; done_cyc0 = 0; busy_cnt0 = 0; busy_first0 = 0; busy_last0 = 0;
    stall_seen0 = 0; stall_viol0 = 0;
    done_cnt1 = 0; done_cyc1 = 0;
  endtask

  task automatic start_dump(input int d);
    @(posedge clk);
    #1;
    if (d == 0) begin
      start0 = 1'b1; start_cyc0 = cyc;
    end else begin
      start1 = 1'b1; start_cyc1 = cyc;
    end
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget, input string tag);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      #1;
      if ((d == 0) ? if0.done_o : if1.done_o) break;
      n++;
    end
    chk({tag, "_done_seen"}, (n < budget), 1'b1);
  endtask

  // Mismatches of a captured stream against the bank, MSB byte first.
  function automatic int byte_errs(input logic [7:0] q[$]);
    int e = 0;
    logic [31:0] w;
    logic [7:0]  b;
    for (int i = 0; i < 128; i++) begin
      w = bank[i / 4];
      b = w[31 - 8 * (i % 4) -: 8];
      if (i >= q.size()) e++;
      else if (q[i] !== b) e++;
    end
    return e + ((q.size() > 128) ? 1 : 0);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hold_err;
    for (int i = 0; i < 32; i++) bank[i] = 32'h0101_0101 * 32'(i);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr",  if0.dump_addr_o, 5'd0);
    chk("rst_data",  if0.tx_data_o,   8'h00);
    chk("rst_valid", if0.tx_valid_o,  1'b0);
    chk("rst_busy",  if0.busy_o,      1'b0);
    chk("rst_done",  if0.done_o,      1'b0);
    rst = 1'b0;

    // Full dump, ready always high
    clear_mon();
    start_dump(0);
    wait_done(0, 400, "t1");
    chk("t1_count",      q0.size(), 128);
    chk("t1_bytes",      byte_errs(q0), 0);
    chk("t1_reg31_msb",  (q0.size() > 124) ? q0[124] : 8'hxx, 8'h1F);
    chk("t1_reg1_lsb",   (q0.size() > 7) ? q0[7] : 8'hxx, 8'h01);
    chk("t1_done_cyc",   done_cyc0, 194);
    chk("t1_done_cnt",   done_cnt0, 1);
    chk("t1_busy_first", busy_first0, 2);
    chk("t1_busy_last",  busy_last0, 193);
    chk("t1_busy_cnt",   busy_cnt0, 192);
    @(negedge clk);
    #1;
    chk("t1_done_pulse", if0.done_o, 1'b0);

    // Back-pressure one-in-three with a distinctive register 5
    bank[5] = 32'hDEAD_BEEF;
    rmode = 1;
    clear_mon();
    start_dump(0);
    wait_done(0, 1500, "t2");
    rmode = 0;
    chk("t2_count", q0.size(), 128);
    chk("t2_bytes", byte_errs(q0), 0);
    chk("t2_reg5",  (q0.size() > 23) ? {q0[20], q0[21], q0[22], q0[23]} : 32'hxxxx_xxxx, 32'hDEAD_BEEF);
    chk("t2_stalls_seen", (stall_seen0 > 0), 1'b1);
    chk("t2_stall_hold",  stall_viol0, 0);
    chk("t2_done_cnt",    done_cnt0, 1);

    // start ignored mid-dump; held through DONE restarts after one IDLE cycle
    clear_mon();
    start_dump(0);
    repeat (48) @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (138) @(posedge clk);
    #1 start0 = 1'b1;
    wait_done(0, 20, "t3");
    chk("t3_count",    q0.size(), 128);
    chk("t3_bytes",    byte_errs(q0), 0);
    chk("t3_done_cyc", done_cyc0, 194);
    chk("t3_done_cnt", done_cnt0, 1);
    @(negedge clk);
    #1;
    chk("t3_idle_gap", if0.busy_o, 1'b0);
    @(negedge clk);
    #1;
    chk("t3_restart", if0.busy_o, 1'b1);
    start0 = 1'b0;
    clear_mon();
    wait_done(0, 400, "t3b");
    chk("t3b_count",    q0.size(), 128);
    chk("t3b_bytes",    byte_errs(q0), 0);
    chk("t3b_done_cnt", done_cnt0, 1);

    // Asynchronous reset mid-byte of register 12
    clear_mon();
    start_dump(0);
    repeat (75) @(posedge clk);
    #3;
    chk("t4_pre_valid", if0.tx_valid_o, 1'b1);
    chk("t4_pre_addr",  if0.dump_addr_o, 5'd12);
    rst = 1'b1;
    #1;
    chk("t4_valid", if0.tx_valid_o, 1'b0);
    chk("t4_busy",  if0.busy_o, 1'b0);
    chk("t4_addr",  if0.dump_addr_o, 5'd0);
    chk("t4_data",  if0.tx_data_o, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("t4_partial", q0.size(), 49);
    chk("t4_no_done", done_cnt0, 0);
    clear_mon();
    start_dump(0);
    wait_done(0, 400, "t4b");
    chk("t4b_count",    q0.size(), 128);
    chk("t4b_bytes",    byte_errs(q0), 0);
    chk("t4b_done_cyc", done_cyc0, 194);

    // Read latency of two cycles
    clear_mon();
    start_dump(1);
    wait_done(1, 500, "t5");
    chk("t5_count",    q1.size(), 128);
    chk("t5_bytes",    byte_errs(q1), 0);
    chk("t5_done_cyc", done_cyc1, 226);
    chk("t5_done_cnt", done_cnt1, 1);

    // Ready low for 1000 cycles on the first byte
    bank[0] = 32'hC311_2233;
    rmode = 2;
    clear_mon();
    start_dump(0);
    repeat (2) @(posedge clk);
    hold_err = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (!(if0.tx_valid_o === 1'b1 && if0.tx_data_o === 8'hC3 && if0.busy_o === 1'b1)) hold_err++;
    end
    chk("t6_hold",     hold_err, 0);
    chk("t6_data",     if0.tx_data_o, 8'hC3);
    chk("t6_no_xfer",  q0.size(), 0);
    rmode = 0;
    wait_done(0, 400, "t6");
    chk("t6_count",      q0.size(), 128);
    chk("t6_bytes",      byte_errs(q0), 0);
    chk("t6_stall_hold", stall_viol0, 0);
    chk("t6_done_cnt",   done_cnt0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
